// File: rtl/muldiv_hilo_unit.sv
// -----------------------------------------------------------------------------
// muldiv_hilo_unit
//   Execute-stage multiply/divide unit. Owns the architectural HI/LO registers
//   and produces the HI/LO read value (hl_out) that travels down the pipeline
//   to writeback. The result of MULT/MULTU/DIV/DIVU is computed when the
//   operation is accepted and held until a busy counter expires, so the
//   hazard unit sees a realistic multi-cycle latency on `busy`.
//
// Ports
//   clk     in   clock, all state updates on posedge
//   reset   in   synchronous, active-high; clears HI/LO and aborts any op
//   start   in   qualifies op this cycle (ignored while busy)
//   op      in   0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6/7=no-op
//   a       in   rs operand (dividend / multiplicand / MTHI/MTLO source)
//   b       in   rt operand (divisor / multiplier)
//   hl_sel  in   0 selects LO, 1 selects HI on hl_out
//   busy    out  multiply/divide in flight
//   hi, lo  out  architectural HI/LO
//   hl_out  out  combinational hl_sel ? hi : lo
// -----------------------------------------------------------------------------
module muldiv_hilo_unit #(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        hl_sel,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] hl_out
);

   localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [63:0]        res_q, res_d;
   // Cleared for divide-by-zero so that completion leaves HI/LO untouched.
   logic               res_wr_q, res_wr_d;
   logic [31:0]        hi_q, hi_d;
   logic [31:0]        lo_q, lo_d;

   // 64-bit product {hi, lo}. Both operands are widened to 64 bits (sign- or
   // zero-extended), so the low 64 bits of the product are exact either way.
   function automatic logic [63:0] mul_full(input logic        is_signed,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
      logic signed [63:0] wx, wy;
      wx = is_signed ? {{32{x[31]}}, x} : {32'd0, x};
      wy = is_signed ? {{32{y[31]}}, y} : {32'd0, y};
      return wx * wy;
   endfunction

   // Returns {remainder, quotient}. Dividing in 64 bits avoids the 32-bit
   // overflow of 0x80000000 / -1: the quotient 2^31 truncates to 0x80000000.
   // Signed / and % truncate toward zero, so the remainder takes the
   // dividend's sign. Callers never use the result for y == 0.
   function automatic logic [63:0] div_full(input logic        is_signed,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
      logic signed [63:0] wx, wy, q, r;
      wx = is_signed ? {{32{x[31]}}, x} : {32'd0, x};
      wy = is_signed ? {{32{y[31]}}, y} : {32'd0, y};
      if (y == 32'd0) begin
         q = '0;
         r = '0;
      end else begin
         q = wx / wy;
         r = wx % wy;
      end
      return {r[31:0], q[31:0]};
   endfunction

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      res_d    = res_q;
      res_wr_d = res_wr_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               case (op)
                  3'd0, 3'd1: begin
                     res_d    = mul_full(op == 3'd0, a, b);
                     res_wr_d = 1'b1;
                     cnt_d    = CNT_W'(MUL_CYCLES);
                     state_d  = RUN;
                  end
                  3'd2, 3'd3: begin
                     res_d    = div_full(op == 3'd2, a, b);
                     res_wr_d = (b != 32'd0);
                     cnt_d    = CNT_W'(DIV_CYCLES);
                     state_d  = RUN;
                  end
                  3'd4:    hi_d = a;
                  3'd5:    lo_d = a;
                  default: ;
               endcase
            end
         end
         RUN: begin
            // start is deliberately not looked at here: nothing is queued.
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = IDLE;
               if (res_wr_q) begin
                  hi_d = res_q[63:32];
                  lo_d = res_q[31:0];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         res_q    <= '0;
         res_wr_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         res_q    <= res_d;
         res_wr_q <= res_wr_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign busy   = (state_q == RUN);
   assign hi     = hi_q;
   assign lo     = lo_q;
   assign hl_out = hl_sel ? hi_q : lo_q;

endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
- Execute-stage multiply/divide unit for the pipelined MIPS core. Owns the architectural HI/LO registers.
- Produces the HI/LO read value that travels down the pipeline to the writeback stage as the HL field. It is the producer end of that path.
- Models multi-cycle latency with a busy counter; the hazard unit uses `busy`/`start` to stall mfhi/mflo/mult/div and mthi/mtlo instructions.

Parameters:
- MUL_CYCLES, 5, busy duration in cycles for MULT/MULTU (must be ≥1)
- DIV_CYCLES, 10, busy duration in cycles for DIV/DIVU (must be ≥1)

Ports:
- clk  input  1  clock, all state updates on posedge
- reset  input  1  synchronous, active-high
- start  input  1  qualifies `op` this cycle
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=no-op
- a  input  32  rs operand (dividend / multiplicand / MTHI/MTLO source)
- b  input  32  rt operand (divisor / multiplier)
- hl_sel  input  1  0 selects LO, 1 selects HI for `hl_out`
- busy  output  1  operation in flight
- hi  output  32  architectural HI register
- lo  output  32  architectural LO register
- hl_out  output  32  combinational mux: `hl_sel ? hi : lo`

Behaviour:
- Reset: clk is the clock; reset is synchronous, active-high. On a reset edge:
  - hi=0, lo=0, busy=0, cycle counter=0.
  - Any pending result is discarded.
  - Reset mid-operation aborts the operation; HI/LO read 0 on the next cycle.
- States: IDLE (busy=0) and RUN (busy=1). Counter `cnt` and a pending-result register `res[63:0]` are internal.
- IDLE, start=1, op∈{0..3}:
  - Compute the result from `a`/`b` sampled at this edge; hold it in `res` (operands are not re-sampled).
  - Load cnt = MUL_CYCLES for op 0/1, or DIV_CYCLES for op 2/3.
  - Go to RUN; busy=1 from the next cycle.
- RUN, each edge: cnt decrements. On the edge where cnt==1:
  - hi=res[63:32], lo=res[31:0], busy=0, go to IDLE.
  - If start is issued at cycle t, busy is high for cycles t+1..t+N and the new HI/LO are visible at t+N+1 (N = MUL_CYCLES or DIV_CYCLES).
- Arithmetic:
  - MULT: 64-bit signed product.
  - MULTU: 64-bit unsigned product.
  - DIV: lo=signed quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (b==0, op 2/3): full busy period still elapses; HI/LO keep their prior values.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps; no trap).
- MTHI/MTLO, start=1 in IDLE: hi (op 4) or lo (op 5) = a at that edge. One-cycle effect, busy stays 0.
- start=1 while busy=1: ignored entirely, any op. Preventing this is the hazard unit's job; this unit never queues.
- start=1 with op 6/7: no effect.
- hl_out is purely combinational from current hi/lo. During RUN it shows the old values; mfhi/mflo must be stalled by the hazard unit while busy||start.
- The final RUN edge and a new start arriving on that same edge: the start is ignored because busy=1 on that cycle. It may be reissued the next cycle.

Test Plan:
- Reset, then hl_sel=0/1 → hl_out=0, busy=0. Assert reset during a DIV at its 4th busy cycle → next cycle busy=0, hi=lo=0, and no late HI/LO update appears.
- start, op=MULT, a=0xFFFFFFFD (−3), b=5 → busy high exactly 5 cycles; on the cycle after, hi=0xFFFFFFFF, lo=0xFFFFFFF1. Changing a/b during busy does not change the result.
- MULTU a=0xFFFFFFFF, b=2 → hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- DIV a=0xFFFFFFF9 (−7), b=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 → lo=3, hi=1.
- Preload hi=0x11111111, lo=0x22222222 via MTHI/MTLO (each visible the next cycle). Then DIVU b=0 → busy 10 cycles, hi/lo unchanged. A MULT start issued during that busy period has no effect.
- Back-to-back: MULT completes, and a MTLO a=0xABCD issued on the first idle cycle → lo=0xABCD the next cycle, hi keeps the MULT result. hl_sel toggles hl_out between the two in the same cycle.
